// File: rtl/half_add_sub_if.sv
`default_nettype none
// ============================================================================
// Module   : half_add_sub_if
// Purpose  : Bundles the operand/result bus of half_add_sub_unit.
//            master drives operands and in_valid, slave returns results.
// Ports    : in_valid, a, b, a1, b1                     (master -> slave)
//            sum, carry, diff, borrow, carry_any,
//            borrow_any, out_valid                      (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface half_add_sub_if #(
  parameter int LANES = 1
);
  logic             in_valid;
  logic [LANES-1:0] a;
  logic [LANES-1:0] b;
  logic [LANES-1:0] a1;
  logic [LANES-1:0] b1;
  logic [LANES-1:0] sum;
  logic [LANES-1:0] carry;
  logic [LANES-1:0] diff;
  logic [LANES-1:0] borrow;
  logic             carry_any;
  logic             borrow_any;
  logic             out_valid;

  modport master (
    output in_valid, a, b, a1, b1,
    input  sum, carry, diff, borrow, carry_any, borrow_any, out_valid
  );

  modport slave (
    input  in_valid, a, b, a1, b1,
    output sum, carry, diff, borrow, carry_any, borrow_any, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/half_add_sub_unit.sv
`default_nettype none
// ============================================================================
// Module   : half_add_sub_unit
// Purpose  : LANES parallel registered half adders (a/b) and half
//            subtractors (a1/b1). Results are captured when in_valid is high
//            and flagged by out_valid one clock later; otherwise they hold.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            bus    - half_add_sub_if slave modport (operands in, results out)
// Revision : 1.0 - initial release
// ============================================================================
module half_add_sub_unit #(
  parameter int LANES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  half_add_sub_if.slave bus
);

  logic [LANES-1:0] sum_d,    sum_q;
  logic [LANES-1:0] carry_d,  carry_q;
  logic [LANES-1:0] diff_d,   diff_q;
  logic [LANES-1:0] borrow_d, borrow_q;
  logic             carry_any_d,  carry_any_q;
  logic             borrow_any_d, borrow_any_q;
  logic             out_valid_q;

  // Each lane is a self-contained cell; nothing crosses lane boundaries.
  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      assign sum_d[i]    = bus.a[i] ^ bus.b[i];
      assign carry_d[i]  = bus.a[i] & bus.b[i];
      assign diff_d[i]   = bus.a1[i] ^ bus.b1[i];
      assign borrow_d[i] = ~bus.a1[i] & bus.b1[i];
    end
  endgenerate

  // Summary flags are reduced from the next-state vectors so they describe
  // exactly the result set captured alongside them.
  assign carry_any_d  = |carry_d;
  assign borrow_any_d = |borrow_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q        <= '0;
      carry_q      <= '0;
      diff_q       <= '0;
      borrow_q     <= '0;
      carry_any_q  <= 1'b0;
      borrow_any_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q        <= sum_d;
        carry_q      <= carry_d;
        diff_q       <= diff_d;
        borrow_q     <= borrow_d;
        carry_any_q  <= carry_any_d;
        borrow_any_q <= borrow_any_d;
      end
    end
  end

  assign bus.sum        = sum_q;
  assign bus.carry      = carry_q;
  assign bus.diff       = diff_q;
  assign bus.borrow     = borrow_q;
  assign bus.carry_any  = carry_any_q;
  assign bus.borrow_any = borrow_any_q;
  assign bus.out_valid  = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_half_add_sub_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_half_add_sub_unit
// Purpose  : Self-checking bench for half_add_sub_unit at LANES=1 and
//            LANES=4, driven side by side from the same operand stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_half_add_sub_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  half_add_sub_if #(.LANES(1)) if1 ();
  half_add_sub_if #(.LANES(4)) if4 ();

  half_add_sub_unit #(.LANES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  half_add_sub_unit #(.LANES(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] a, b, a1, b1;
    logic [3:0] s, c, d, bo;
    logic       ca, ba;
  } vec_t;
  vec_t tbl [8];

  // Current stimulus (mirrors what is on both interfaces).
  logic [3:0] ia, ib, ia1, ib1;
  logic       iv;

  // Reference model state.
  logic [3:0] m4_s, m4_c, m4_d, m4_b;
  logic       m4_ca, m4_ba;
  logic [3:0] m1_s, m1_c, m1_d, m1_b;
  logic       m1_ca, m1_ba;
  logic       m_ov;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Per-lane arithmetic: a+b as a 2-bit number, a1-b1 as a signed integer.
  task automatic ref_op(input logic [3:0] a, b, a1, b1, input int n,
                        output logic [3:0] s, c, d, bo,
                        output logic ca, ba);
    s = '0; c = '0; d = '0; bo = '0;
    for (int k = 0; k < n; k++) begin
      int t;
      int u;
      t = int'(a[k]) + int'(b[k]);
      u = int'(a1[k]) - int'(b1[k]);
      s[k]  = (t % 2) != 0;
      c[k]  = (t >= 2);
      bo[k] = (u < 0);
      d[k]  = (u != 0);
    end
    ca = |c;
    ba = |bo;
  endtask

  task automatic model_clear();
    m4_s = '0; m4_c = '0; m4_d = '0; m4_b = '0; m4_ca = 0; m4_ba = 0;
    m1_s = '0; m1_c = '0; m1_d = '0; m1_b = '0; m1_ca = 0; m1_ba = 0;
    m_ov = 1'b0;
  endtask

  task automatic model_edge();
    m_ov = iv;
    if (iv) begin
      ref_op(ia, ib, ia1, ib1, 4, m4_s, m4_c, m4_d, m4_b, m4_ca, m4_ba);
      ref_op(ia, ib, ia1, ib1, 1, m1_s, m1_c, m1_d, m1_b, m1_ca, m1_ba);
    end
  endtask

  task automatic drive(input logic [3:0] a, b, a1, b1, input logic v);
    ia = a; ib = b; ia1 = a1; ib1 = b1; iv = v;
    if4.a = a; if4.b = b; if4.a1 = a1; if4.b1 = b1; if4.in_valid = v;
    if1.a = a[0]; if1.b = b[0]; if1.a1 = a1[0]; if1.b1 = b1[0]; if1.in_valid = v;
  endtask

  task automatic check_model(string tag);
    chk({tag, "_u4"},
        {if4.sum, if4.carry, if4.diff, if4.borrow,
         if4.carry_any, if4.borrow_any, if4.out_valid},
        {m4_s, m4_c, m4_d, m4_b, m4_ca, m4_ba, m_ov});
    chk({tag, "_u1"},
        {if1.sum, if1.carry, if1.diff, if1.borrow,
         if1.carry_any, if1.borrow_any, if1.out_valid},
        {m1_s[0], m1_c[0], m1_d[0], m1_b[0], m1_ca, m1_ba, m_ov});
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    //            a        b        a1       b1       s        c        d        bo      ca ba
    tbl[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    tbl[1] = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 0, 1};
    tbl[2] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0, 0};
    tbl[3] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1, 0};
    tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    tbl[5] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 1, 1};
    tbl[6] = '{4'b1100, 4'b1010, 4'b0101, 4'b0011, 4'b0110, 4'b1000, 4'b0110, 4'b0010, 1, 1};
    tbl[7] = '{4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 1, 1};

    // Reset held with live operands and in_valid high across clock edges.
    drive(4'hF, 4'hF, 4'h0, 4'hF, 1'b1);
    model_clear();
    repeat (2) @(negedge clk);
    check_model("reset");

    // First capture happens on the first edge after release.
    rst_n = 1'b1;
    drive(4'b0011, 4'b0101, 4'b1010, 4'b0110, 1'b1);
    step("first_cap");

    // Back-to-back table vectors against hand-written expectations.
    for (int k = 0; k < 8; k++) begin
      drive(tbl[k].a, tbl[k].b, tbl[k].a1, tbl[k].b1, 1'b1);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk($sformatf("tbl%0d_u4", k),
          {if4.sum, if4.carry, if4.diff, if4.borrow,
           if4.carry_any, if4.borrow_any, if4.out_valid},
          {tbl[k].s, tbl[k].c, tbl[k].d, tbl[k].bo, tbl[k].ca, tbl[k].ba, 1'b1});
      chk($sformatf("tbl%0d_u1", k),
          {if1.sum, if1.carry, if1.diff, if1.borrow,
           if1.carry_any, if1.borrow_any, if1.out_valid},
          {tbl[k].s[0], tbl[k].c[0], tbl[k].d[0], tbl[k].bo[0],
           tbl[k].c[0], tbl[k].bo[0], 1'b1});
    end

    // Hold: capture 1+0, then present 1+1 with in_valid low.
    drive(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step("hold_cap");
    drive(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step("hold");
      chk("hold_sum",   {31'd0, if1.sum},       32'd1);
      chk("hold_carry", {31'd0, if1.carry},     32'd0);
      chk("hold_ov",    {31'd0, if1.out_valid}, 32'd0);
    end

    // Randomized traffic against the reference model.
    for (int k = 0; k < 300; k++) begin
      drive(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom_range(0, 1)));
      step("rand");
    end

    // Mid-operation asynchronous reset, between clock edges.
    drive(4'hF, 4'hF, 4'h0, 4'hF, 1'b1);
    step("pre_rst");
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_clear();
    #1 check_model("async_rst");
    @(negedge clk);
    drive(4'hF, 4'hF, 4'h0, 4'hF, 1'b0);
    @(negedge clk);
    check_model("rst_held");
    rst_n = 1'b1;
    repeat (2) step("post_rst_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/half_add_sub_unit.md
Name: half_add_sub_unit

Overview:
- Registered pair of independent bitwise arithmetic cells: a half adder on operands a/b and a half subtractor on operands a1/b1.
- Each cell is replicated across LANES parallel bit lanes.
- Results are captured on the clock edge when in_valid is high, and flagged by out_valid.
- Used as a small leaf arithmetic primitive and as a reference block for gate-level arithmetic checks.

Parameters:
- LANES, 1, number of independent bit lanes per cell (>=1). Lane i uses bit i of every operand and result vector.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  capture enable; operands are sampled when high
- a  input  LANES  adder operand A
- b  input  LANES  adder operand B
- a1  input  LANES  subtractor minuend
- b1  input  LANES  subtractor subtrahend
- sum  output  LANES  registered a XOR b
- carry  output  LANES  registered a AND b
- diff  output  LANES  registered a1 XOR b1
- borrow  output  LANES  registered (NOT a1) AND b1
- carry_any  output  1  registered OR-reduction of the captured carry vector
- borrow_any  output  1  registered OR-reduction of the captured borrow vector
- out_valid  output  1  high for one cycle after each capture

Behaviour:
- Reset: rst_n low asynchronously forces sum, carry, diff, borrow, carry_any, borrow_any and out_valid to 0. This takes effect immediately, mid-operation included, and holds while rst_n is low.
- Deassertion of rst_n is treated as synchronous to clk; the first capture can occur on the first rising edge with rst_n high.
- Capture, on a rising edge with in_valid=1, for each lane i:
  - sum[i] <= a[i]^b[i]
  - carry[i] <= a[i]&b[i]
  - diff[i] <= a1[i]^b1[i]
  - borrow[i] <= ~a1[i]&b1[i]
  - carry_any <= |(a&b)
  - borrow_any <= |(~a1&b1)
- Latency is exactly one clock from sampled operands to registered results.
- Hold: on a rising edge with in_valid=0, all result registers retain their values.
- out_valid timing:
  - out_valid <= in_valid on every rising edge.
  - Back-to-back in_valid gives continuous out_valid.
  - Each result set is valid for the cycle in which out_valid is high; it stays stable afterwards until the next capture.
- Lane independence:
  - No carry or borrow propagates between lanes.
  - Adder and subtractor operands are fully independent; changing a/b never affects diff/borrow, and changing a1/b1 never affects sum/carry.
- Per-lane truth table (a,b -> sum,carry | a1,b1 -> diff,borrow):
  - 00 -> 0,0 | 0,0
  - 01 -> 1,0 | 1,1
  - 10 -> 1,0 | 1,0
  - 11 -> 0,1 | 0,0
- Arithmetic identities per lane:
  - {carry,sum} = a+b, 2-bit unsigned.
  - a1-b1 = diff - 2*borrow.
- No X propagation from unused state: every register has a defined reset value.
- Operands are not registered separately; only results are stored.

Test Plan:
- Reset: drive rst_n=0 with operands nonzero and in_valid=1 -> all outputs 0 immediately, without waiting for a clock edge. Release rst_n -> first capture on the next edge.
- Exhaustive truth table, LANES=1: apply (a,b)=(a1,b1) = 00, 01, 10, 11, 00, one per clock with in_valid=1 -> one cycle later:
  - sum/carry = 0/0, 1/0, 1/0, 0/1, 0/0
  - diff/borrow = 0/0, 1/1, 1/0, 0/0, 0/0
  - out_valid high throughout.
- Independent operands: a=1,b=1,a1=0,b1=1 -> sum=0, carry=1, diff=1, borrow=1, carry_any=1, borrow_any=1.
- Hold: capture a=1,b=0, then drop in_valid and change to a=1,b=1 for 3 clocks -> sum stays 1, carry stays 0, out_valid=0 after the first cycle.
- Multi-lane, LANES=4: a=4'b1100, b=4'b1010, a1=4'b0101, b1=4'b0011 -> sum=0110, carry=1000, diff=0110, borrow=0010, carry_any=1, borrow_any=1.
- Mid-operation reset: stream valid data, pull rst_n low between clock edges -> outputs and out_valid drop to 0 at once. After release with in_valid=0, outputs stay 0.
